// File: rtl/uart_prog_loader.sv
// Serial program loader: UART bytes -> framed 16-bit words -> program RAM write port.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module uart_prog_loader #(
    parameter int unsigned       CLKS_PER_BIT   = 434,
    parameter int unsigned       ADDR_W         = 8,
    parameter logic [ADDR_W-1:0] START_ADDR     = '0,
    parameter int unsigned       TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_in,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    output logic              err_sticky
);

    localparam int unsigned     CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]      SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {S_IDLE, S_COUNT, S_HI, S_LO, S_CHK} state_e;

    logic [1:0]       rx_sync_q;
    logic             rx_prev_q;
    logic             rx_s;
    rx_state_e        rx_state_q;
    logic [CNT_W-1:0] clk_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             byte_valid_q;
    logic             frame_err_q;

    state_e           state_q;
    logic [8:0]       words_q;
    logic [7:0]       hi_q;
    logic [7:0]       sum_q;
    logic [7:0]       chk_sum;
    logic             timeout_hit;

    assign rx_s    = rx_sync_q[1];
    assign chk_sum = sum_q + shift_q;
    assign busy    = (state_q != S_IDLE);

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync_q <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rx_in};
            rx_prev_q <= rx_s;
        end
    end

    // UART receiver: start re-checked at half bit, data and stop sampled mid-bit
    always_ff @(posedge clk) begin
        byte_valid_q <= 1'b0;
        frame_err_q  <= 1'b0;
        if (reset) begin
            rx_state_q <= RX_IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_s) begin
                        rx_state_q <= RX_START;
                        clk_cnt_q  <= '0;
                    end
                end
                RX_START: begin
                    if (clk_cnt_q == HALF_BIT) begin
                        clk_cnt_q  <= '0;
                        bit_cnt_q  <= '0;
                        rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (clk_cnt_q == FULL_BIT) begin
                        clk_cnt_q <= '0;
                        shift_q   <= {rx_s, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (clk_cnt_q == FULL_BIT) begin
                        clk_cnt_q    <= '0;
                        rx_state_q   <= RX_IDLE;
                        byte_valid_q <= rx_s;
                        frame_err_q  <= !rx_s;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q;

    // Idle time since the last received byte while a frame is open
    always_ff @(posedge clk) begin
        if (reset || byte_valid_q || state_q == S_IDLE) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end

    assign timeout_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) && !byte_valid_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
`endif

    // Frame parser and RAM write sequencing
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ram_we     <= 1'b0;
            ram_addr   <= START_ADDR;
            ram_wdata  <= '0;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            err_sticky <= 1'b0;
            words_q    <= '0;
            hi_q       <= '0;
            sum_q      <= '0;
        end else begin
            ram_we    <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            if (state_q != S_IDLE && (frame_err_q || timeout_hit)) begin
                state_q    <= S_IDLE;
                load_err   <= 1'b1;
                err_sticky <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (byte_valid_q && shift_q == SYNC_BYTE) begin
                            state_q    <= S_COUNT;
                            cpu_hold   <= 1'b1;
                            err_sticky <= 1'b0;
                            ram_addr   <= START_ADDR;
                            sum_q      <= '0;
                        end
                    end
                    S_COUNT: begin
                        if (byte_valid_q) begin
                            words_q <= (shift_q == 8'd0) ? 9'd256 : {1'b0, shift_q};
                            state_q <= S_HI;
                        end
                    end
                    S_HI: begin
                        if (byte_valid_q) begin
                            hi_q    <= shift_q;
                            sum_q   <= sum_q + shift_q;
                            state_q <= S_LO;
                        end
                    end
                    S_LO: begin
                        // ram_we high means the write just went out: advance pointer and count
                        if (ram_we) begin
                            ram_addr <= ram_addr + ADDR_W'(1);
                            words_q  <= words_q - 9'd1;
                            state_q  <= (words_q == 9'd1) ? S_CHK : S_HI;
                        end else if (byte_valid_q) begin
                            ram_we    <= 1'b1;
                            ram_wdata <= {hi_q, shift_q};
                            sum_q     <= sum_q + shift_q;
                        end
                    end
                    S_CHK: begin
                        if (byte_valid_q) begin
                            state_q <= S_IDLE;
                            if (chk_sum == 8'd0) begin
                                load_done <= 1'b1;
                                cpu_hold  <= 1'b0;
                            end else begin
                                load_err   <= 1'b1;
                                err_sticky <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: directed frames plus random frames against a frame-level model.
module tb_uart_prog_loader;

    localparam int unsigned CPB   = 8;
    localparam int unsigned AW    = 8;
    localparam logic [7:0]  START = 8'h00;
    localparam int unsigned TMO   = 200;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_in;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          load_done;
    logic          load_err;
    logic          err_sticky;

    always #5 clk = ~clk;

    uart_prog_loader #(
        .CLKS_PER_BIT  (CPB),
        .ADDR_W        (AW),
        .START_ADDR    (START),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_in     (rx_in),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .load_done (load_done),
        .load_err  (load_err),
        .err_sticky(err_sticky)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Observed bus activity
    logic [23:0] obs_wr[$];
    int          obs_done = 0;
    int          obs_err  = 0;
    int          viol     = 0;
    logic        prev_we  = 1'b0;

    always @(negedge clk) begin
        if (ram_we) begin
            obs_wr.push_back({ram_addr, ram_wdata});
            if (prev_we || !busy) viol++;
        end
        prev_we = ram_we;
        if (load_done) obs_done++;
        if (load_err) obs_err++;
    end

    // Frame-level reference model state
    logic [23:0] exp_wr[$];
    int          exp_done   = 0;
    int          exp_err    = 0;
    logic        exp_hold   = 1'b0;
    logic        exp_sticky = 1'b0;
    logic        exp_busy   = 1'b0;
    logic [7:0]  exp_addr   = START;

    // Walks a byte stream that starts with the loader idle and updates the expectations
    task automatic model_bytes(input logic [7:0] q[$]);
        int         i = 0;
        int         n;
        logic [7:0] sum;
        exp_busy = 1'b0;
        while (i < q.size()) begin
            if (q[i] != 8'hA5) begin
                i++;
                continue;
            end
            exp_hold   = 1'b1;
            exp_sticky = 1'b0;
            exp_addr   = START;
            exp_busy   = 1'b1;
            i++;
            if (i >= q.size()) break;
            n = (q[i] == 8'd0) ? 256 : int'(q[i]);
            i++;
            sum = 8'd0;
            for (int w = 0; w < n; w++) begin
                if (i + 1 >= q.size()) begin
                    i = q.size();
                    break;
                end
                exp_wr.push_back({exp_addr, q[i], q[i+1]});
                sum      = sum + q[i] + q[i+1];
                exp_addr = exp_addr + 8'd1;
                i += 2;
            end
            if (i >= q.size()) break;
            if (8'(sum + q[i]) == 8'd0) begin
                exp_done++;
                exp_hold = 1'b0;
            end else begin
                exp_err++;
                exp_sticky = 1'b1;
            end
            exp_busy = 1'b0;
            i++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop, input int gap_bits);
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_in = !bad_stop;
        repeat (CPB) @(negedge clk);
        rx_in = 1'b1;
        repeat (gap_bits * CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] q[$], input int gap_bits);
        foreach (q[i]) send_byte(q[i], 1'b0, gap_bits);
    endtask

    task automatic verify(input string tag);
        int m;
        repeat (4 * CPB) @(negedge clk);
        check($sformatf("%s nwr", tag), 32'(obs_wr.size()), 32'(exp_wr.size()));
        m = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
        for (int i = 0; i < m; i++) check($sformatf("%s wr%0d", tag, i), 32'(obs_wr[i]), 32'(exp_wr[i]));
        check($sformatf("%s done", tag), 32'(obs_done), 32'(exp_done));
        check($sformatf("%s err", tag), 32'(obs_err), 32'(exp_err));
        check($sformatf("%s hold", tag), 32'(cpu_hold), 32'(exp_hold));
        check($sformatf("%s sticky", tag), 32'(err_sticky), 32'(exp_sticky));
        check($sformatf("%s busy", tag), 32'(busy), 32'(exp_busy));
        check($sformatf("%s addr", tag), 32'(ram_addr), 32'(exp_addr));
        check($sformatf("%s we_rule", tag), 32'(viol), 32'd0);
        obs_wr.delete();
        exp_wr.delete();
        obs_done = 0; obs_err = 0; exp_done = 0; exp_err = 0; viol = 0;
    endtask

    task automatic pulse_reset_and_check(input string tag);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check($sformatf("%s rst_we", tag), 32'(ram_we), 32'd0);
        check($sformatf("%s rst_wdata", tag), 32'(ram_wdata), 32'd0);
        check($sformatf("%s rst_addr", tag), 32'(ram_addr), 32'(START));
        check($sformatf("%s rst_hold", tag), 32'(cpu_hold), 32'd0);
        check($sformatf("%s rst_busy", tag), 32'(busy), 32'd0);
        check($sformatf("%s rst_done", tag), 32'(load_done), 32'd0);
        check($sformatf("%s rst_err", tag), 32'(load_err), 32'd0);
        check($sformatf("%s rst_sticky", tag), 32'(err_sticky), 32'd0);
        exp_hold = 1'b0; exp_sticky = 1'b0; exp_busy = 1'b0; exp_addr = START;
    endtask

    logic [7:0] f1[$]  = '{8'hA5, 8'h02, 8'h10, 8'h05, 8'h30, 8'h03, 8'hB8};
    logic [7:0] f1b[$] = '{8'hA5, 8'h02, 8'h10, 8'h05, 8'h30, 8'h03, 8'hB9};
    logic [7:0] f3[$]  = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h80, 8'h00, 8'h80};

    initial begin
        logic [7:0] fr[$];
        logic [7:0] sum;
        logic [7:0] b;
        int         nw;

        reset = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        pulse_reset_and_check("init");
        repeat (2 * CPB) @(negedge clk);

        // Basic two-word load
        send_frame(f1, 1); model_bytes(f1); verify("t1");

        // Bad checksum, then recovery
        send_frame(f1b, 1); model_bytes(f1b); verify("t2a");
        send_frame(f1, 1);  model_bytes(f1);  verify("t2b");

        // Junk before sync
        send_frame(f3, 1); model_bytes(f3); verify("t3");

        // Framing error on lo byte of word 0
        fr = '{8'hA5, 8'h02, 8'h10};
        send_frame(fr, 1); model_bytes(fr);
        send_byte(8'h05, 1'b1, 1);
        exp_err++; exp_sticky = 1'b1; exp_busy = 1'b0;
        verify("t4");

        // Reset after hi byte of word 1
        fr = '{8'hA5, 8'h02, 8'h10, 8'h05, 8'h30};
        send_frame(fr, 1); model_bytes(fr);
        pulse_reset_and_check("t5");
        verify("t5a");
        send_frame(f1, 1); model_bytes(f1); verify("t5b");

        // Stalled host
        fr = '{8'hA5, 8'h03};
        send_frame(fr, 1); model_bytes(fr);
`ifdef LOADER_TIMEOUT_EN
        repeat (150) @(negedge clk);
        check("t6 early_err", 32'(obs_err), 32'd0);
        repeat (100) @(negedge clk);
        exp_err++; exp_sticky = 1'b1; exp_busy = 1'b0;
`else
        repeat (300) @(negedge clk);
`endif
        verify("t6");
        pulse_reset_and_check("t6r");

        // Random frames with optional junk and corrupted checksums
        for (int k = 0; k < 8; k++) begin
            fr.delete();
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h5A;
                fr.push_back(b);
            end
            nw = int'($urandom_range(1, 5));
            fr.push_back(8'hA5);
            fr.push_back(8'(nw));
            sum = 8'd0;
            for (int w = 0; w < 2 * nw; w++) begin
                b = 8'($urandom_range(0, 255));
                fr.push_back(b);
                sum = sum + b;
            end
            b = 8'd0 - sum;
            if ($urandom_range(0, 3) == 0) b = b + 8'($urandom_range(1, 255));
            fr.push_back(b);
            send_frame(fr, int'($urandom_range(0, 2)));
            model_bytes(fr);
            verify($sformatf("rnd%0d", k));
        end

        // Count byte 0 means 256 words; address wraps back to START
        fr = '{8'hA5, 8'h00};
        sum = 8'd0;
        for (int w = 0; w < 512; w++) begin
            b = 8'($urandom_range(0, 255));
            fr.push_back(b);
            sum = sum + b;
        end
        fr.push_back(8'd0 - sum);
        send_frame(fr, 0);
        model_bytes(fr);
        verify("n256");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
Serial program loader that writes instruction words into the CPU's 16-bit program RAM. It receives a framed byte stream on a UART RX line and assembles 16-bit words, high (opcode) byte first. It writes each word through the same RAM write port the datapath uses, and holds the CPU off while loading. It is the write side of the instruction path the IR/decoder reads, and the input counterpart of the ACC serial output.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); minimum 4
ADDR_W, 8, RAM address width
START_ADDR, 8'h00, address of first loaded word
TIMEOUT_CYCLES, 1000000, inter-byte timeout; used only with LOADER_TIMEOUT_EN

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
rx_in  input  1  UART RX line, idle high, asynchronous to clk
ram_we  output  1  one-cycle RAM write strobe
ram_addr  output  ADDR_W  write address
ram_wdata  output  16  write data {hi_byte, lo_byte}
cpu_hold  output  1  high while a load is in progress; top level keeps PC/IR in reset and muxes the RAM port to the loader
busy  output  1  high in any state other than IDLE
load_done  output  1  one-cycle pulse on a successful load
load_err  output  1  one-cycle pulse on a failed load
err_sticky  output  1  set on load_err, cleared by the next sync byte or by reset

Behaviour:
- Reset: all outputs 0; ram_addr = START_ADDR; FSM in IDLE; UART receiver idle.
- UART RX path:
  - rx_in passes through a 2-flop synchroniser.
  - A start bit is a falling edge; the line is re-checked low at half a bit.
  - Eight data bits are sampled at mid-bit, LSB first.
  - The stop bit is sampled at mid-bit. Stop = 0 is a framing error.
  - Each received byte produces an internal 1-cycle byte_valid.
- Frame format: 0xA5 sync, then count N (0 means 256 words), then N × {hi, lo}, then checksum C.
  - Valid when (sum of all hi/lo bytes + C) mod 256 = 0.
  - The count byte is excluded from the sum.
- FSM states: IDLE, COUNT, HI, LO, CHK.
  - IDLE: bytes other than 0xA5 are ignored, and framing errors are ignored. On 0xA5: go to COUNT, cpu_hold <= 1, err_sticky <= 0, ram_addr <= START_ADDR, sum <= 0.
  - COUNT: latch N (9-bit word counter, 0 maps to 256), go to HI.
  - HI: latch hi byte, add it to sum, go to LO.
  - LO: add lo byte to sum. In the cycle after lo's byte_valid: ram_we = 1, ram_wdata = {hi, lo}, ram_addr = current address. In the following cycle ram_addr increments (wraps modulo 2^ADDR_W) and the counter decrements. When the counter reaches 0, go to CHK; otherwise go to HI.
  - CHK: when (sum + C) mod 256 = 0, pulse load_done and drop cpu_hold. Otherwise pulse load_err, set err_sticky, and keep cpu_hold high. Either way, go to IDLE.
- Failed load: cpu_hold stays 1 until a successful load or reset, so the CPU never runs a corrupt image.
- Framing error in COUNT, HI, LO or CHK: load_err pulse, err_sticky set, return to IDLE, no further writes. Words already written stay in RAM.
- ram_we is never asserted outside LO and is never high for 2 consecutive cycles.
- Reset mid-load: synchronous. Any in-flight write is suppressed if reset is high in that cycle. FSM returns to IDLE, cpu_hold = 0.
- Sync byte 0xA5 inside a frame: treated as data, not as a resync.
- busy = (state != IDLE). cpu_hold can be 1 while busy is 0 (after an error).

Optional Feature:
LOADER_TIMEOUT_EN
- Defined: a counter resets on every byte_valid and counts while busy. When it reaches TIMEOUT_CYCLES: load_err pulse, err_sticky set, return to IDLE, cpu_hold stays high.
- Undefined: no timeout counter; a stalled host leaves the FSM waiting indefinitely.

Test Plan:
(All scenarios use CLKS_PER_BIT = 8.)
1. Send A5 02 10 05 30 03 B8 -> RAM[0] = 16'h1005, RAM[1] = 16'h3003; exactly 2 ram_we pulses; load_done once; cpu_hold falls after CHK.
2. Same frame with checksum 0xB9 -> both words written, load_err pulse, err_sticky = 1, cpu_hold stays 1. Then resend the frame from test 1 -> load_done, err_sticky = 0, cpu_hold = 0.
3. Send 00 FF then A5 01 80 00 80 in IDLE -> bytes before A5 ignored; RAM[0] = 16'h8000; load_done.
4. Force the stop bit low on the lo byte of word 0 -> load_err, no ram_we; FSM returns to IDLE.
5. Assert reset for 1 cycle after the hi byte of word 1 -> no further writes; all outputs 0; a subsequent full frame loads correctly from START_ADDR.
6. With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES = 200: send A5 03 then stop -> load_err 200 cycles after the last byte_valid; without the macro, no load_err.
